// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, the control
// unit's mocsr encoding, funct3 operation encodings and mstatus bit positions.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        MOCSR_NONE  = 2'b00,
        MOCSR_CSR   = 2'b01,
        MOCSR_MRET  = 2'b10,
        MOCSR_ECALL = 2'b11
    } mocsr_e;

    // funct3[1:0]; funct3[2] only selects the immediate form, which the
    // control unit already reports on csr_inm.
    localparam logic [1:0] F3_RW = 2'b01;
    localparam logic [1:0] F3_RS = 2'b10;
    localparam logic [1:0] F3_RC = 2'b11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit software write ports.
// Ports:
//   clk, rst_n    clock and async active-low reset
//   inc           advance the counter by one this cycle
//   wr_lo, wr_hi  load wdata into the low / high word
//   wdata         software write data
//   lo, hi        current counter value split into words
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [63:0] cnt;

    // A write to either half suppresses the increment of the whole counter,
    // so software sees exactly the value it wrote on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) cnt[31:0]  <= wdata;
            if (wr_hi) cnt[63:32] <= wdata;
        end else if (inc) begin
            cnt <= cnt + 64'd1;
        end
    end

    assign lo = cnt[31:0];
    assign hi = cnt[63:32];

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file and trap state for the rv32i core.
// Ports:
//   clk, rst_n          core clock, async active-low reset
//   mocsr               00 none, 01 CSR instr, 10 mret, 11 ecall
//   csr_w, csr_inm, f3  write request, zimm operand select, funct3
//   csr_addr            addressed CSR
//   rs1_data, zimm      operand sources
//   pc, retire          current PC, instruction completes this cycle
//   csr_rdata           old value of addressed CSR (0 unless mocsr=01)
//   illegal_csr         unmapped access or write to a read-only CSR
//   redirect            ecall/mret redirect request
//   redirect_pc         mtvec for ecall, mepc for mret
//   mie_out             mstatus.MIE
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] MISA_VAL  = 32'h40000100,
    parameter logic [31:0] MTVEC_RST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mocsr,
    input  logic        csr_w,
    input  logic        csr_inm,
    input  logic [2:0]  f3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic [31:0] pc,
    input  logic        retire,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        mie_out
);

    logic        mie, mpie;
    logic [31:0] mtvec, mepc, mcause, mscratch;
    logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;

    logic [31:0] op, old, wdata;
    logic        mapped, is_csr, zero_set_clr, write_attempt, we;

    // pc[1:0] is always dropped from mepc; f3[2] is carried by csr_inm.
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], f3[2]};

    assign is_csr        = (mocsr == MOCSR_CSR);
    assign op            = csr_inm ? {27'b0, zimm} : rs1_data;
    assign zero_set_clr  = f3[1] && (op == 32'd0);
    assign write_attempt = csr_w && !zero_set_clr;

    always_comb begin
        mapped = 1'b1;
        old    = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                old[12:11]          = 2'b11;
                old[MSTATUS_MPIE]   = mpie;
                old[MSTATUS_MIE]    = mie;
            end
            CSR_MISA:                   old = MISA_VAL;
            CSR_MTVEC:                  old = mtvec;
            CSR_MSCRATCH:               old = mscratch;
            CSR_MEPC:                   old = mepc;
            CSR_MCAUSE:                 old = mcause;
            CSR_MCYCLE,   CSR_CYCLE:    old = mcycle_lo;
            CSR_MCYCLEH,  CSR_CYCLEH:   old = mcycle_hi;
            CSR_MINSTRET, CSR_INSTRET:  old = minstret_lo;
            CSR_MINSTRETH,CSR_INSTRETH: old = minstret_hi;
            CSR_MHARTID:                old = HART_ID;
            default:                    mapped = 1'b0;
        endcase
    end

    always_comb begin
        case (f3[1:0])
            F3_RS:   wdata = old | op;
            F3_RC:   wdata = old & ~op;
            default: wdata = op;
        endcase
    end

    assign illegal_csr = is_csr && (!mapped || ((csr_addr[11:10] == 2'b11) && write_attempt));
    assign we          = csr_w && is_csr && !illegal_csr && !zero_set_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RST;
            mepc     <= '0;
            mcause   <= '0;
            mscratch <= '0;
        end else if (mocsr == MOCSR_ECALL) begin
            mepc   <= {pc[31:2], 2'b00};
            mcause <= MCAUSE_ECALL_M;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mocsr == MOCSR_MRET) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie  <= wdata[MSTATUS_MIE];
                    mpie <= wdata[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec    <= {wdata[31:2], 2'b00};
                CSR_MSCRATCH: mscratch <= wdata;
                CSR_MEPC:     mepc     <= {wdata[31:2], 2'b00};
                CSR_MCAUSE:   mcause   <= wdata;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (we && (csr_addr == CSR_MCYCLE)),
        .wr_hi (we && (csr_addr == CSR_MCYCLEH)),
        .wdata (wdata),
        .lo    (mcycle_lo),
        .hi    (mcycle_hi)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .wr_lo (we && (csr_addr == CSR_MINSTRET)),
        .wr_hi (we && (csr_addr == CSR_MINSTRETH)),
        .wdata (wdata),
        .lo    (minstret_lo),
        .hi    (minstret_hi)
    );

    assign csr_rdata   = is_csr ? old : 32'd0;
    assign redirect    = mocsr[1];
    assign redirect_pc = (mocsr == MOCSR_ECALL) ? mtvec :
                         (mocsr == MOCSR_MRET)  ? mepc  : 32'd0;
    assign mie_out     = mie;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file. Inputs change just after the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mocsr;
    logic        csr_w;
    logic        csr_inm;
    logic [2:0]  f3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mie_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mocsr       (mocsr),
        .csr_w       (csr_w),
        .csr_inm     (csr_inm),
        .f3          (f3),
        .csr_addr    (csr_addr),
        .rs1_data    (rs1_data),
        .zimm        (zimm),
        .pc          (pc),
        .retire      (retire),
        .csr_rdata   (csr_rdata),
        .illegal_csr (illegal_csr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mie_out     (mie_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Apply an instruction's CSR inputs for the current cycle and let them settle.
    task automatic apply(input logic [1:0] m, input logic w, input logic inm,
                         input logic [2:0] fn, input logic [11:0] a,
                         input logic [31:0] rs1, input logic [4:0] z);
        mocsr = m; csr_w = w; csr_inm = inm; f3 = fn;
        csr_addr = a; rs1_data = rs1; zimm = z;
        #1;
    endtask

    task automatic idle();
        apply(2'b00, 1'b0, 1'b0, 3'b000, 12'h000, 32'd0, 5'd0);
    endtask

    // Pure read of a CSR (CSRRS with rs1=x0 and no write request).
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        apply(2'b01, 1'b0, 1'b0, 3'b010, a, 32'd0, 5'd0);
        check(tag, csr_rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0; pc = 32'd0; retire = 1'b0;
        idle();
        step();
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_misa", 12'h301, 32'h4000_0100);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        idle();
        check("rdata_idle_zero", csr_rdata, 32'd0);
        step();
        rst_n = 1'b1;

        // mcycle counts one per rising edge after release
        repeat (10) step();
        rd("mcycle_10", 12'hB00, 32'd10);
        rd("mcycleh_0", 12'hB80, 32'd0);
        rd("minstret_0", 12'hB02, 32'd0);
        rd("mstatus_idle", 12'h300, 32'h0000_1800);

        // CSRRW mscratch
        step();
        apply(2'b01, 1'b1, 1'b0, 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0);
        check("rw_old", csr_rdata, 32'd0);
        check("rw_legal", {31'd0, illegal_csr}, 32'd0);
        step();
        rd("rw_new", 12'h340, 32'hDEAD_BEEF);

        // CSRRS with zero operand: no write; CSRRCI with 0x0F clears low nibble
        step();
        apply(2'b01, 1'b1, 1'b0, 3'b010, 12'h340, 32'd0, 5'd0);
        check("rs0_old", csr_rdata, 32'hDEAD_BEEF);
        step();
        rd("rs0_keep", 12'h340, 32'hDEAD_BEEF);
        step();
        apply(2'b01, 1'b1, 1'b1, 3'b111, 12'h340, 32'hFFFF_FFFF, 5'h0F);
        step();
        rd("rci_clear", 12'h340, 32'hDEAD_BEE0);

        // set MIE, program mtvec (low bits masked off)
        step();
        apply(2'b01, 1'b1, 1'b1, 3'b110, 12'h300, 32'd0, 5'd8);
        step();
        rd("mstatus_mie", 12'h300, 32'h0000_1808);
        check("mie_out_1", {31'd0, mie_out}, 32'd1);
        step();
        apply(2'b01, 1'b1, 1'b0, 3'b001, 12'h305, 32'h0000_0203, 5'd0);
        step();
        rd("mtvec_mask", 12'h305, 32'h0000_0200);

        // ecall with a misaligned pc and a stray write request on mscratch
        step();
        pc = 32'h0000_0126;
        apply(2'b11, 1'b1, 1'b0, 3'b001, 12'h340, 32'h1111_1111, 5'd0);
        check("ecall_redirect", {31'd0, redirect}, 32'd1);
        check("ecall_pc", redirect_pc, 32'h0000_0200);
        check("ecall_rdata_zero", csr_rdata, 32'd0);
        step();
        rd("ecall_mepc", 12'h341, 32'h0000_0124);
        rd("ecall_mcause", 12'h342, 32'd11);
        rd("ecall_mstatus", 12'h300, 32'h0000_1880);
        rd("ecall_no_write", 12'h340, 32'hDEAD_BEE0);
        check("ecall_mie_out", {31'd0, mie_out}, 32'd0);
        step();
        apply(2'b10, 1'b0, 1'b0, 3'b000, 12'h000, 32'd0, 5'd0);
        check("mret_redirect", {31'd0, redirect}, 32'd1);
        check("mret_pc", redirect_pc, 32'h0000_0124);
        step();
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // 64-bit carry, write-overrides-increment, other half holds
        step();
        apply(2'b01, 1'b1, 1'b0, 3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0);
        step();
        rd("mcycle_ff", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_before", 12'hB80, 32'd0);
        idle();
        step();
        rd("mcycle_wrap_lo", 12'hB00, 32'd0);
        rd("mcycle_wrap_hi", 12'hB80, 32'd1);
        rd("cycleh_shadow", 12'hC80, 32'd1);
        step();
        apply(2'b01, 1'b1, 1'b0, 3'b001, 12'hB00, 32'h1234_5678, 5'd0);
        step();
        rd("mcycle_wr_wins", 12'hB00, 32'h1234_5678);
        apply(2'b01, 1'b1, 1'b0, 3'b001, 12'hB80, 32'd5, 5'd0);
        step();
        rd("mcycleh_wr", 12'hB80, 32'd5);
        rd("mcycle_lo_hold", 12'hB00, 32'h1234_5678);

        // minstret follows retire
        idle();
        retire = 1'b1;
        repeat (3) step();
        retire = 1'b0;
        rd("minstret_3", 12'hB02, 32'd3);
        rd("instret_shadow", 12'hC02, 32'd3);

        // mcycle lo is now 0x1234567B
        apply(2'b01, 1'b1, 1'b0, 3'b001, 12'hC00, 32'd0, 5'd0);
        check("ill_wr_ro", {31'd0, illegal_csr}, 32'd1);
        step();
        apply(2'b01, 1'b0, 1'b0, 3'b010, 12'h7C0, 32'd0, 5'd0);
        check("ill_unmapped", {31'd0, illegal_csr}, 32'd1);
        step();
        apply(2'b01, 1'b1, 1'b0, 3'b010, 12'hC00, 32'd0, 5'd0);
        check("rs0_ro_legal", {31'd0, illegal_csr}, 32'd0);
        check("rs0_ro_cycle", csr_rdata, 32'h1234_567D);
        apply(2'b01, 1'b1, 1'b1, 3'b101, 12'hF14, 32'd0, 5'd3);
        check("ill_mhartid_wr", {31'd0, illegal_csr}, 32'd1);
        apply(2'b01, 1'b1, 1'b0, 3'b001, 12'h301, 32'h0, 5'd0);
        check("misa_wr_legal", {31'd0, illegal_csr}, 32'd0);
        step();
        rd("misa_unchanged", 12'h301, 32'h4000_0100);
        rd("minstret_kept", 12'hB02, 32'd3);

        // reset mid-instruction discards the pending write
        step();
        apply(2'b01, 1'b1, 1'b0, 3'b001, 12'h340, 32'h0000_0055, 5'd0);
        rst_n = 1'b0;
        #1;
        rd("midrst_mstatus", 12'h300, 32'h0000_1800);
        step();
        rd("midrst_mscratch", 12'h340, 32'd0);
        rd("midrst_mcycle", 12'hB00, 32'd0);
        rst_n = 1'b1;
        step();
        rd("post_rst_mcycle", 12'hB00, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
